// File: rtl/fifo_modport.sv
// Synchronous single-clock FIFO with registered read port, registered flags/count,
// and one-cycle overflow/underflow pulses. Pointers carry an extra wrap bit.
module fifo_modport #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  write_full,
    output logic                  read_empty,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

    logic rd_acc;
    logic wr_acc;

    always_comb begin
        rd_acc = read_en && !empty_q;
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        wr_acc = write_en && (!full_q || rd_acc);

        wptr_d      = wptr_q + PW'(wr_acc);
        rptr_d      = rptr_q + PW'(rd_acc);
        count_d     = wptr_d - rptr_d;
        empty_d     = (wptr_d == rptr_d);
        full_d      = (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
                      (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
        overflow_d  = write_en && !wr_acc;
        underflow_d = read_en && !rd_acc;

        read_data_d = read_data_q;
        if (rd_acc) begin
            read_data_d = mem[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // Storage is not reset; the empty flag guarantees unwritten words are never read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            read_data_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            read_data_q <= read_data_d;
        end
    end

    assign read_data  = read_data_q;
    assign write_full = full_q;
    assign read_empty = empty_q;
    assign waddr      = wptr_q[ADDR_WIDTH-1:0];
    assign raddr      = rptr_q[ADDR_WIDTH-1:0];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_modport.sv
// Bench for fifo_modport: a queue-based reference model checked against every output
// each cycle, plus literal expectations for the directed scenarios.
module tb_fifo_modport;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          write_en = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          read_en = 1'b0;
    logic [DW-1:0] read_data;
    logic          write_full;
    logic          read_empty;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    fifo_modport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .write_full (write_full),
        .read_empty (read_empty),
        .waddr      (waddr),
        .raddr      (raddr),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] q [$];
    int            wcnt;
    int            rcnt;
    logic [DW-1:0] m_rd;
    logic          m_ovf;
    logic          m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        wcnt  = 0;
        rcnt  = 0;
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic compare_all();
        chk("read_data",  32'(read_data),  32'(m_rd));
        chk("write_full", 32'(write_full), 32'(q.size() == DEPTH));
        chk("read_empty", 32'(read_empty), 32'(q.size() == 0));
        chk("count",      32'(count),      32'(q.size()));
        chk("waddr",      32'(waddr),      32'(wcnt % DEPTH));
        chk("raddr",      32'(raddr),      32'(rcnt % DEPTH));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("underflow",  32'(underflow),  32'(m_unf));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
        logic rd_ok;
        logic wr_ok;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        @(posedge clk);
        rd_ok = re && (q.size() > 0);
        wr_ok = we && ((q.size() < DEPTH) || rd_ok);
        m_ovf = we && !wr_ok;
        m_unf = re && !rd_ok;
        if (rd_ok) begin
            m_rd = q.pop_front();
            rcnt++;
        end
        if (wr_ok) begin
            q.push_back(wd);
            wcnt++;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_literals(input string tag);
        chk({tag, "_count"},      32'(count),      32'd0);
        chk({tag, "_read_empty"}, 32'(read_empty), 32'd1);
        chk({tag, "_write_full"}, 32'(write_full), 32'd0);
        chk({tag, "_read_data"},  32'(read_data),  32'd0);
        chk({tag, "_waddr"},      32'(waddr),      32'd0);
        chk({tag, "_raddr"},      32'(raddr),      32'd0);
        chk({tag, "_overflow"},   32'(overflow),   32'd0);
        chk({tag, "_underflow"},  32'(underflow),  32'd0);
    endtask

    initial begin
        model_clear();
        #2 rst = 1'b0;
        #1 check_reset_literals("por");
        @(negedge clk);
        rst = 1'b1;

        // Scenario 1: three writes, three reads
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        chk("s1_count3", 32'(count), 32'd3);
        cycle(1'b0, 8'h00, 1'b1);
        chk("s1_rd0", 32'(read_data), 32'h11);
        cycle(1'b0, 8'h00, 1'b1);
        chk("s1_rd1", 32'(read_data), 32'h22);
        cycle(1'b0, 8'h00, 1'b1);
        chk("s1_rd2", 32'(read_data), 32'h33);
        chk("s1_empty", 32'(read_empty), 32'd1);

        // Scenario 2: fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        chk("s2_full", 32'(write_full), 32'd1);
        chk("s2_count16", 32'(count), 32'd16);
        cycle(1'b1, 8'hAA, 1'b0);
        chk("s2_overflow", 32'(overflow), 32'd1);
        chk("s2_count_after_ovf", 32'(count), 32'd16);
        cycle(1'b0, 8'h00, 1'b0);
        chk("s2_overflow_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("s2_drain", 32'(read_data), 32'(i));
        end
        chk("s2_empty", 32'(read_empty), 32'd1);

        // Scenario 3: underflow leaves state alone; write+read on empty takes only the write
        cycle(1'b0, 8'h00, 1'b1);
        chk("s3_underflow", 32'(underflow), 32'd1);
        chk("s3_read_data_held", 32'(read_data), 32'h0F);
        chk("s3_raddr", 32'(raddr), 32'd3);
        chk("s3_empty", 32'(read_empty), 32'd1);
        cycle(1'b1, 8'h77, 1'b1);
        chk("s3_wr_rd_empty_unf", 32'(underflow), 32'd1);
        chk("s3_wr_rd_empty_count", 32'(count), 32'd1);
        chk("s3_wr_rd_empty_data", 32'(read_data), 32'h0F);
        cycle(1'b0, 8'h00, 1'b1);
        chk("s3_rd77", 32'(read_data), 32'h77);

        // Scenario 4: simultaneous access while full, then continuous streaming across wrap
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        cycle(1'b1, 8'h80, 1'b1);
        chk("s4_rd_oldest", 32'(read_data), 32'h40);
        chk("s4_full_kept", 32'(write_full), 32'd1);
        chk("s4_count16", 32'(count), 32'd16);
        chk("s4_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h90 + i), 1'b1);
        chk("s4_stream_rd", 32'(read_data), 32'h93);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("s4_last", 32'(read_data), 32'hA3);

        // Partial fill with simultaneous access keeps count steady
        cycle(1'b1, 8'hC1, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b1);
        chk("s4_partial_count", 32'(count), 32'd2);
        chk("s4_partial_rd", 32'(read_data), 32'hC1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Scenario 5: asynchronous reset between edges with five words stored
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        write_en = 1'b0;
        read_en  = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_literals("mid");
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0);
        chk("s5_waddr_after_wr", 32'(waddr), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("s5_rd5a", 32'(read_data), 32'h5A);
        chk("s5_empty", 32'(read_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_modport.md
FIFO_MODPORT -- requirements
Module: fifo_modport

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the width of each stored word in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, is the address width; DEPTH = 2**ADDR_WIDTH words (16 by default).
REQ-003 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset is asynchronous and active-low.
REQ-005 Port write_en, input, 1 bit, write request.
REQ-006 Port write_data, input, DATA_WIDTH bits, word to store.
REQ-007 Port read_en, input, 1 bit, read request.
REQ-008 Port read_data, output, DATA_WIDTH bits, registered read word.
REQ-009 Port write_full, output, 1 bit, FIFO holds DEPTH words.
REQ-010 Port read_empty, output, 1 bit, FIFO holds 0 words.
REQ-011 Port waddr, output, ADDR_WIDTH bits, current write address (debug).
REQ-012 Port raddr, output, ADDR_WIDTH bits, current read address (debug).
REQ-013 Port count, output, ADDR_WIDTH+1 bits, number of stored words, 0..DEPTH.
REQ-014 Port overflow, output, 1 bit, one-cycle pulse when a write is rejected.
REQ-015 Port underflow, output, 1 bit, one-cycle pulse when a read is rejected.

Function
REQ-016 Storage SHALL be a DEPTH x DATA_WIDTH memory with first-in first-out ordering.
REQ-017 Write accept = write_en and (not write_full, or read accepted in the same cycle).
- On accept: mem[waddr] <= write_data; waddr increments.
REQ-018 Read accept = read_en and not read_empty.
- On accept: read_data <= mem[raddr] on that edge, a one-cycle read latency; raddr increments.
REQ-019 read_data SHALL hold its last value when no read is accepted.
REQ-020 waddr and raddr SHALL wrap from DEPTH-1 to 0.
REQ-021 Internal pointers SHALL be ADDR_WIDTH+1 bits; the extra MSB is the wrap bit.
- waddr and raddr SHALL be the low ADDR_WIDTH bits.
REQ-022 write_full SHALL be 1 when the pointers differ only in their MSB.
REQ-023 read_empty SHALL be 1 when the pointers are equal.
REQ-024 count SHALL equal the write pointer minus the read pointer, modulo 2**(ADDR_WIDTH+1).
REQ-025 Flags and count SHALL be registered and updated on the same edge as the pointers, with no extra lag.
REQ-026 Simultaneous read and write when empty: the write SHALL be accepted, the read rejected (no bypass), and underflow SHALL pulse.
REQ-027 Simultaneous read and write when full: both SHALL be accepted; count stays DEPTH and write_full stays 1.
REQ-028 Simultaneous read and write when partially filled: both SHALL be accepted; count is unchanged.
REQ-029 overflow SHALL be 1 for exactly the cycle after an edge where write_en=1 and the write was rejected; otherwise 0.
- Rejected writes SHALL not modify memory or pointers.
REQ-030 underflow SHALL be 1 for exactly the cycle after an edge where read_en=1 and the read was rejected.
- Rejected reads SHALL leave read_data unchanged.
REQ-031 Read values SHALL come from memory only; uninitialized memory SHALL never be read.

Reset
REQ-032 rst=0 SHALL immediately, without waiting for clk, clear:
- waddr=0, raddr=0, count=0
- read_data=0
- read_empty=1, write_full=0
- overflow=0, underflow=0
REQ-033 Memory contents need not be cleared.
REQ-034 Reset asserted mid-operation SHALL discard all stored words.
REQ-035 The first write accepted after rst returns to 1 SHALL store at address 0.

Verification
REQ-036 Scenario 1: reset, then write 0x11,0x22,0x33, then read 3 -> read_data = 0x11,0x22,0x33, one cycle after each read; read_empty=1 after the third read.
REQ-037 Scenario 2: write 16 words 0x00..0x0F -> write_full=1 and count=16.
- A 17th write (0xAA) -> overflow pulses and is dropped.
- 16 reads -> 0x00..0x0F in order.
REQ-038 Scenario 3: read_en=1 with the FIFO empty -> underflow pulses; read_data, raddr and read_empty unchanged.
REQ-039 Scenario 4: with 16 words stored, assert write_en and read_en together -> oldest word read, new word stored, write_full stays 1, count=16.
- Then write/read 20 words continuously -> waddr and raddr wrap 15->0 and the data order is preserved.
REQ-040 Scenario 5: reset asserted between clock edges with 5 words stored -> outputs clear immediately (count=0, read_empty=1, read_data=0).
- A subsequent write of 0x5A then a read returns 0x5A.
